// File: rtl/mult_seq.sv
// mult_seq: iterative radix-2 shift-add multiplier for MULT/MULTU.
// The operands are multiplied as unsigned magnitudes. A final cycle applies the
// two's-complement fix-up for signed operations that have a negative result.
// The partial-sum adder is a chain of 4-bit carry-lookahead groups, with the
// carry rippling from group to group.

// 4-bit carry-lookahead group: all internal carries are computed from g/p.
module mult_seq_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  // Generate/propagate terms, lookahead carries, then the sum bits.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end
endmodule

// Top level: FSM, operand and product registers, result registers.
// WIDTH must be a multiple of 4 so the adder splits evenly into lookahead groups.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam int NG = WIDTH / 4;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   add_sum;
  logic [NG:0]        grp_c;

  // The CLA chain adds the multiplicand into the upper half of the product register.
  assign grp_c[0] = 1'b0;
  for (genvar g = 0; g < NG; g++) begin : g_cla
    mult_seq_cla4 u_grp (
      .a    (prod_q[WIDTH + 4*g +: 4]),
      .b    (mcand_q[4*g +: 4]),
      .cin  (grp_c[g]),
      .s    (add_sum[4*g +: 4]),
      .cout (grp_c[g+1])
    );
  end

  // Operand magnitudes. The most negative value maps to itself, which is
  // the correct magnitude when it is read as unsigned.
  always_comb begin
    a_abs = a;
    b_abs = b;
    if (is_signed && a[WIDTH-1]) a_abs = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
    if (is_signed && b[WIDTH-1]) b_abs = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Next-state, datapath and output logic.
  // FIX returns to IDLE and leaves busy high for one more cycle. On that
  // retire cycle, hi/lo are loaded and done pulses, so busy and done change
  // together. A start is accepted only once busy has dropped.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = (state_q != IDLE);
    done_d  = 1'b0;

    if (state_q == IDLE && busy_q) begin
      hi_d   = prod_q[2*WIDTH-1:WIDTH];
      lo_d   = prod_q[WIDTH-1:0];
      done_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          mcand_d = a_abs;
          prod_d  = {{WIDTH{1'b0}}, b_abs};
          cnt_d   = '0;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d = RUN;
        end
      end
      RUN: begin
        // {carry, upper+mcand, lower} shifted right by one.
        if (prod_q[0]) prod_d = {grp_c[NG], add_sum, prod_q[WIDTH-1:1]};
        else           prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (neg_q) prod_d = ~prod_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq. Each accepted operation pushes a reference
// product and its start edge onto a scoreboard. Each done pulse pops one entry
// and checks the value and the latency.
module tb_mult_seq;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          is_signed_i = 1'b0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  logic [2*W-1:0] exp_q [$];
  int             edge_q [$];

  mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed_i),
    .a         (a_i),
    .b         (b_i),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every done pulse must match the oldest pending entry.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    int st;
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with nothing pending", hi, lo);
      end else begin
        e  = exp_q.pop_front();
        st = edge_q.pop_front();
        if ({hi, lo} !== e) begin
          errors++;
          $display("FAIL result: got %h_%h expected %h_%h", hi, lo, e[2*W-1:W], e[W-1:0]);
        end
        checks++;
        if (cyc - st != LAT) begin
          errors++;
          $display("FAIL latency: got %0d edges expected %0d", cyc - st, LAT);
        end
      end
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high on two consecutive cycles");
      end
    end
    prev_done = done;
  end

  // Must be called at a negedge. Drives start for one edge. If track is set,
  // the reference product and the start edge are pushed to the scoreboard.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sg, input logic track);
    logic signed [2*W-1:0] sx, sy;
    logic [2*W-1:0] e;
    a_i = av; b_i = bv; is_signed_i = sg; start = 1'b1;
    if (sg) begin
      sx = $signed({{W{av[W-1]}}, av});
      sy = $signed({{W{bv[W-1]}}, bv});
      e  = sx * sy;
    end else begin
      e = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
    end
    if (track) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (track) edge_q.push_back(cyc);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", nm, n);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (hi !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    if (lo !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int nb = 0;
    int n = 0;
    start_op(32'd3, 32'd5, 1'b0, 1'b1);
    while (!done && n < 200) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    checks += 2;
    if (nb != W + 1) begin errors++; $display("FAIL busy_len: got %0d expected %0d", nb, W + 1); end
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", busy); end
    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done("multu_max");
    @(negedge clk);
  endtask

  task automatic test_mult_signed;
    logic [W-1:0] av [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0007};
    logic [W-1:0] bv [5] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFF0};
    for (int i = 0; i < 5; i++) begin
      start_op(av[i], bv[i], 1'b1, 1'b1);
      wait_done("mult_signed");
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    start_op(32'd7, 32'd9, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    // Ignored while busy; these operand changes must not disturb 7*9.
    start_op(32'd2, 32'd2, 1'b0, 1'b0);
    wait_done("first");
    // Start on the done cycle itself.
    start_op(32'd2, 32'd2, 1'b0, 1'b1);
    wait_done("back_to_back");
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    start_op(32'h1234, 32'h10, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    if (hi !== '0) begin errors++; $display("FAIL rst_hi: got %h expected 0", hi); end
    if (lo !== '0) begin errors++; $display("FAIL rst_lo: got %h expected 0", lo); end
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
    start_op(32'h1234, 32'h10, 1'b0, 1'b1);
    wait_done("after_rst");
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_back_to_back();
    test_rst_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d results never completed, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
